uart_fifo_periph: RTL

//  Next-generation UART peripheral on the tramelblaze port bus.
//  - Wraps the existing tx_engine/rx_engine with parametrised TX/RX FIFOs.
//  - Replaces the fixed baud table with a programmable 19-bit divisor k.
//  - Adds a register map and a maskable, acknowledged interrupt.
//  - Sits between tramelblaze_top (port_id/in_port/out_port/strobes/interrupt) and the rx/tx pins.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_fifo_periph_if.sv | 21 ++
 rtl/rx_engine.sv | 78 +++++++
 rtl/tx_engine.sv | 58 +++++
 rtl/uart_fifo.sv | 44 ++++
 rtl/uart_fifo_periph.sv | 176 +++++++++++++++++
 6 files changed

// File: rtl/uart_pkg.sv
// Shared register map, ctrl/status bit positions and TX sequencer states
// for the uart_fifo_periph block.
package uart_pkg;

    localparam logic [15:0] OFS_DATA = 16'd0;
    localparam logic [15:0] OFS_STAT = 16'd1;
    localparam logic [15:0] OFS_CTRL = 16'd2;
    localparam logic [15:0] OFS_KLO  = 16'd3;
    localparam logic [15:0] OFS_KHI  = 16'd4;

    localparam int C_EIGHT = 0;
    localparam int C_PEN   = 1;
    localparam int C_OHEL  = 2;
    localparam int C_RXIE  = 3;
    localparam int C_TXIE  = 4;
    localparam int C_LOOP  = 5;

    localparam int S_RXNE   = 0;
    localparam int S_TXE    = 1;
    localparam int S_TXFULL = 2;
    localparam int S_PERR   = 3;
    localparam int S_FERR   = 4;
    localparam int S_RXOVF  = 5;
    localparam int S_TXOVF  = 6;
    localparam int S_RXFULL = 7;

    typedef enum logic [1:0] {
        T_IDLE,
        T_LOAD,
        T_BUSY
    } tx_state_t;

endpackage

// File: rtl/uart_fifo_periph_if.sv
// tramelblaze port bus as seen by a peripheral: address, data,
// strobes and the acknowledged interrupt line.
interface uart_fifo_periph_if;
    logic [15:0] port_id;
    logic [15:0] out_port;
    logic [15:0] in_port;
    logic        write_strobe;
    logic        read_strobe;
    logic        int_ack;
    logic        interrupt;

    modport master (
        output port_id, out_port, write_strobe, read_strobe, int_ack,
        input  in_port, interrupt
    );

    modport slave (
        input  port_id, out_port, write_strobe, read_strobe, int_ack,
        output in_port, interrupt
    );
endinterface

// File: rtl/rx_engine.sv
// Deserialiser: falling-edge start detect, samples mid-bit every k clocks,
// flags framing and parity errors; rxrdy holds until clr.
module rx_engine (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic [18:0] k,
    input  logic        eight,
    input  logic        pen,
    input  logic        even,
    input  logic        clr,
    output logic [7:0]  data,
    output logic        rxrdy,
    output logic        ferr,
    output logic        perr,
    output logic        ovf
);
    logic [2:0]  sync;
    logic        act, half, pbit, tick, rs;
    logic [18:0] cnt, lim;
    logic [3:0]  idx, nd;
    logic [7:0]  sh;

    assign rs   = sync[1];
    assign nd   = eight ? 4'd8 : 4'd7;
    assign lim  = half ? (k >> 1) : k;
    assign tick = ({1'b0, cnt} + 20'd1) >= {1'b0, lim};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= '1;
            act   <= 1'b0;
            half  <= 1'b0;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
            pbit  <= 1'b0;
            data  <= '0;
            rxrdy <= 1'b0;
            ferr  <= 1'b0;
            perr  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            sync <= {sync[1:0], rx};
            if (clr) rxrdy <= 1'b0;
            if (!act) begin
                // Only a high-to-low edge starts a frame
                if (sync[2] && !sync[1]) begin
                    act  <= 1'b1;
                    half <= 1'b1;
                    cnt  <= '0;
                    idx  <= '0;
                    sh   <= '0;
                end
            end else if (tick) begin
                cnt  <= '0;
                half <= 1'b0;
                idx  <= idx + 4'd1;
                if (idx == 4'd0) begin
                    if (rs) act <= 1'b0;
                end else if (idx <= nd) begin
                    sh[3'(idx - 4'd1)] <= rs;
                end else if (pen && idx == nd + 4'd1) begin
                    pbit <= rs;
                end else begin
                    act   <= 1'b0;
                    data  <= sh;
                    ferr  <= ~rs;
                    perr  <= pen & (pbit ^ (^sh) ^ ~even);
                    ovf   <= rxrdy & ~clr;
                    rxrdy <= 1'b1;
                end
            end else begin
                cnt <= cnt + 19'd1;
            end
        end
    end
endmodule

// File: rtl/tx_engine.sv
// Serialiser: start, 7/8 data bits LSB first, optional parity, one stop;
// each bit lasts k clocks.
module tx_engine (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [7:0]  data,
    input  logic [18:0] k,
    input  logic        eight,
    input  logic        pen,
    input  logic        even,
    output logic        tx,
    output logic        txrdy
);
    logic        busy, tick;
    logic [18:0] cnt;
    logic [3:0]  idx, last;
    logic [10:0] sh, frame;
    logic [7:0]  d;

    assign d     = eight ? data : {1'b0, data[6:0]};
    assign last  = 4'd8 + {3'd0, eight} + {3'd0, pen};
    assign tick  = ({1'b0, cnt} + 20'd1) >= {1'b0, k};
    assign tx    = sh[0];
    assign txrdy = ~busy;

    always_comb begin
        frame      = '1;
        frame[0]   = 1'b0;
        frame[8:1] = d;
        if (!eight) frame[8] = 1'b1;
        if (pen) frame[{3'b100, eight}] = ^d ^ ~even;
    end

    // Ones shift in from the top so the line idles high after the stop bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
            idx  <= '0;
            sh   <= '1;
        end else if (!busy) begin
            if (load) begin
                busy <= 1'b1;
                cnt  <= '0;
                idx  <= '0;
                sh   <= frame;
            end
        end else if (tick) begin
            cnt <= '0;
            sh  <= {1'b1, sh[10:1]};
            if (idx >= last) busy <= 1'b0;
            else             idx  <= idx + 4'd1;
        end else begin
            cnt <= cnt + 19'd1;
        end
    end
endmodule

// File: rtl/uart_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted only when a pop
// happens in the same cycle, and a pop from an empty FIFO is ignored.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rp];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/uart_fifo_periph.sv
// UART peripheral with TX/RX FIFOs, programmable divisor and interrupt.
// Define UART_LOOPBACK_EN to enable the ctrl[5] internal loopback.
module uart_fifo_periph
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] BASE_ADDR  = 16'h0000,
    parameter logic [18:0] DEFAULT_K  = 19'd10417
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic tx,
    uart_fifo_periph_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [5:0]    ctrl;
    logic [18:0]   k;
    logic          tx_ovf, rx_ovf;
    logic [15:0]   ofs, status;
    logic          wr_data, rd_data, rd_stat;
    logic [7:0]    tx_head, rx_byte;
    logic          tx_full, tx_empty, tx_load;
    logic [9:0]    rx_head, rx_word;
    logic          rx_full, rx_empty, rx_push;
    logic [CW-1:0] tx_count_unused, rx_count_unused;
    logic          eng_tx, eng_rx, txrdy, loop;
    logic          rxrdy, rxrdy_q, ferr, perr, ovf_unused;
    logic          src, src_q, irq;
    tx_state_t     st, st_n;
    logic [1:0]    hold, hold_n;

    assign ofs     = bus.port_id - BASE_ADDR;
    assign wr_data = bus.write_strobe && ofs == OFS_DATA;
    assign rd_data = bus.read_strobe && ofs == OFS_DATA;
    assign rd_stat = bus.read_strobe && ofs == OFS_STAT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl   <= '0;
            k      <= DEFAULT_K;
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (bus.write_strobe) begin
                case (ofs)
`ifdef UART_LOOPBACK_EN
                    OFS_CTRL: ctrl <= bus.out_port[5:0];
`else
                    OFS_CTRL: ctrl <= {1'b0, bus.out_port[4:0]};
`endif
                    OFS_KLO:  k[15:0]  <= bus.out_port;
                    OFS_KHI:  k[18:16] <= bus.out_port[2:0];
                    default:  ;
                endcase
            end
            // A new overflow in the clearing cycle stays visible
            if (rd_stat) begin
                tx_ovf <= 1'b0;
                rx_ovf <= 1'b0;
            end
            if (wr_data && tx_full && !tx_load) tx_ovf <= 1'b1;
            if (rx_push && rx_full && !rd_data) rx_ovf <= 1'b1;
        end
    end

    assign status = {8'h00, rx_full, tx_ovf, rx_ovf,
                     rx_head[9] & ~rx_empty,
                     rx_head[8] & ~rx_empty,
                     tx_full, tx_empty, ~rx_empty};

    always_comb begin
        bus.in_port = '0;
        case (ofs)
            OFS_DATA: if (!rx_empty) bus.in_port = {6'd0, rx_head};
            OFS_STAT: bus.in_port = status;
            OFS_CTRL: bus.in_port = {10'd0, ctrl};
            OFS_KLO:  bus.in_port = k[15:0];
            OFS_KHI:  bus.in_port = {13'd0, k[18:16]};
            default:  bus.in_port = '0;
        endcase
    end

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset),
        .push(wr_data), .pop(tx_load),
        .din(bus.out_port[7:0]), .dout(tx_head),
        .full(tx_full), .empty(tx_empty),
        .count(tx_count_unused)
    );

    uart_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset),
        .push(rx_push), .pop(rd_data),
        .din(rx_word), .dout(rx_head),
        .full(rx_full), .empty(rx_empty),
        .count(rx_count_unused)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st   <= T_IDLE;
            hold <= '0;
        end else begin
            st   <= st_n;
            hold <= hold_n;
        end
    end

    // txrdy is still high for a cycle or two after load; hold masks it
    always_comb begin
        st_n    = st;
        hold_n  = hold;
        tx_load = 1'b0;
        case (st)
            T_IDLE: if (txrdy && !tx_empty) st_n = T_LOAD;
            T_LOAD: begin
                tx_load = 1'b1;
                hold_n  = '0;
                st_n    = T_BUSY;
            end
            T_BUSY: begin
                if (hold != 2'd2) hold_n = hold + 2'd1;
                else if (txrdy)   st_n   = T_IDLE;
            end
            default: st_n = T_IDLE;
        endcase
    end

`ifdef UART_LOOPBACK_EN
    assign loop = ctrl[C_LOOP];
`else
    assign loop = 1'b0;
`endif
    assign eng_rx = loop ? eng_tx : rx;
    assign tx     = loop ? 1'b1 : eng_tx;

    tx_engine u_tx (
        .clk(clk), .reset(reset),
        .load(tx_load), .data(tx_head), .k(k),
        .eight(ctrl[C_EIGHT]), .pen(ctrl[C_PEN]),
        .even(~ctrl[C_OHEL]),
        .tx(eng_tx), .txrdy(txrdy)
    );

    rx_engine u_rx (
        .clk(clk), .reset(reset),
        .rx(eng_rx), .k(k),
        .eight(ctrl[C_EIGHT]), .pen(ctrl[C_PEN]),
        .even(~ctrl[C_OHEL]), .clr(rx_push),
        .data(rx_byte), .rxrdy(rxrdy),
        .ferr(ferr), .perr(perr), .ovf(ovf_unused)
    );

    assign rx_word = {ferr, perr, rx_byte};
    assign src = (ctrl[C_RXIE] & ~rx_empty) |
                 (ctrl[C_TXIE] & tx_empty);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxrdy_q <= 1'b0;
            rx_push <= 1'b0;
            src_q   <= 1'b0;
            irq     <= 1'b0;
        end else begin
            rxrdy_q <= rxrdy;
            rx_push <= rxrdy & ~rxrdy_q;
            src_q   <= src;
            if (src && !src_q)    irq <= 1'b1;
            else if (bus.int_ack) irq <= 1'b0;
        end
    end

    assign bus.interrupt = irq;
endmodule
